spi_cfg_loader: RTL

SPI_CFG_LOADER -- requirements
Module: spi_cfg_loader

---
 rtl/spi_cfg_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_cfg_loader.sv
// rtl/spi_cfg_loader.sv - shadow register table uploaded word-by-word over a 3-wire SPI link
module spi_cfg_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 12,
  parameter int NUM_REGS = 16,
  parameter int CLK_DIV  = 2,
  parameter int GAP_CYC  = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS = {
    12'h0DB, 12'h6DB, 12'hADF, 12'hFB0, 12'h0F0, 12'h055, 12'h06B, 12'h04A,
    12'h1E1, 12'h000, 12'h000, 12'h002, 12'h0A0, 12'h000, 12'h000, 12'h028}
) (
  input  logic                          clock_20,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [$clog2(NUM_REGS)-1:0]   first_idx,
  input  logic [$clog2(NUM_REGS)-1:0]   last_idx,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          spi_clk,
  output logic                          spi_en,
  output logic                          spi_dat
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int MAXC   = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [WORD_W-1:0]   shreg;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [IDX_W-1:0]    cur_idx, last_q, load_idx;
  logic                hi, hi_next;
  logic                cnt_clr, load, shift, bit_inc, range_latch, done_set, err_set;
  logic                div_end, gap_end, range_ok, wr_ok;

  assign div_end  = (cnt == CNT_W'(CLK_DIV - 1));
  assign gap_end  = (cnt == CNT_W'(GAP_CYC - 1));
  assign range_ok = (first_idx <= last_idx) && ({1'b0, last_idx} < NUM_REGS_C);
  assign wr_ok    = ({1'b0, wr_idx} < NUM_REGS_C);
  assign load_idx = (state == IDLE) ? first_idx : cur_idx + IDX_W'(1);

  always_ff @(posedge clock_20 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // The last bit has no low phase of its own: TRAIL takes its place.
  always_comb begin
    state_next  = state;
    hi_next     = hi;
    cnt_clr     = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    bit_inc     = 1'b0;
    range_latch = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (range_ok) begin
          state_next  = LEAD;
          load        = 1'b1;
          range_latch = 1'b1;
          cnt_clr     = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      LEAD: if (div_end) begin
        state_next = SHIFT;
        cnt_clr    = 1'b1;
        hi_next    = 1'b1;
      end
      SHIFT: if (div_end) begin
        cnt_clr = 1'b1;
        if (hi) begin
          if (bit_cnt == BIT_W'(WORD_W - 1)) begin
            state_next = TRAIL;
          end else begin
            hi_next = 1'b0;
            shift   = 1'b1;
          end
        end else begin
          hi_next = 1'b1;
          bit_inc = 1'b1;
        end
      end
      TRAIL: if (div_end) begin
        state_next = GAP;
        cnt_clr    = 1'b1;
      end
      GAP: if (gap_end) begin
        cnt_clr = 1'b1;
        if (cur_idx < last_q) begin
          state_next = LEAD;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_20 or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      hi      <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      cur_idx <= '0;
      last_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= done_set;
      err  <= err_set;
      hi   <= hi_next;
      cnt  <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (range_latch) last_q <= last_idx;
      if (load) begin
        shreg   <= {ADDR_W'(load_idx), regs[load_idx]};
        cur_idx <= load_idx;
        bit_cnt <= '0;
      end else begin
        if (shift)   shreg   <= {shreg[WORD_W-2:0], 1'b0};
        if (bit_inc) bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_20 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DEFAULTS[i*DATA_W +: DATA_W];
    end else if (wr_en && wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign busy    = (state != IDLE);
  assign spi_en  = !((state == LEAD) || (state == SHIFT) || (state == TRAIL));
  assign spi_clk = (state == SHIFT) && hi;
  assign spi_dat = ((state == LEAD) || (state == SHIFT)) ? shreg[WORD_W-1] : 1'b0;

endmodule
